decode_stage_pipe: RTL

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_stage_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-through bypass, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic              reg_write_d,
    input  logic              alu_src_d,
    input  logic              mem_write_d,
    input  logic              result_src_d,
    input  logic              branch_d,
    input  logic [ALUC_W-1:0] alu_control_d,
    input  logic [1:0]        imm_src_d,
    input  logic              reg_write_w,
    input  logic [RAW-1:0]    rd_w,
    input  logic [XLEN-1:0]   result_w,
    input  logic              hold_e,
    input  logic              flush,
    output logic              stall_d,
    output logic              valid_e,
    output logic              reg_write_e,
    output logic              alu_src_e,
    output logic              mem_write_e,
    output logic              result_src_e,
    output logic              branch_e,
    output logic [ALUC_W-1:0] alu_control_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [RAW-1:0]    rs1_e,
    output logic [RAW-1:0]    rs2_e,
    output logic [RAW-1:0]    rd_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              result_src;
        logic              branch;
        logic [ALUC_W-1:0] alu_control;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [RAW-1:0]    rs1;
        logic [RAW-1:0]    rs2;
        logic [RAW-1:0]    rd;
    } idex_t;

    logic [RAW-1:0]  rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;
    logic [XLEN-1:0] regs [NREGS];
    logic            hazard;
    logic            unused_opcode;
    idex_t           d_s, e_q;

    assign rs1_d = instr_d[15 +: RAW];
    assign rs2_d = instr_d[20 +: RAW];
    assign rd_d  = instr_d[7 +: RAW];
    assign unused_opcode = ^instr_d[6:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (reg_write_w && rd_w != '0) begin
            regs[rd_w] <= result_w;
        end
    end

    // Same-cycle writeback is forwarded so the ID/EX latch sees the new value.
    always_comb begin
        rd1_d = regs[rs1_d];
        if (reg_write_w && rd_w == rs1_d) rd1_d = result_w;
        if (rs1_d == '0) rd1_d = '0;
        rd2_d = regs[rs2_d];
        if (reg_write_w && rd_w == rs2_d) rd2_d = result_w;
        if (rs2_d == '0) rd2_d = '0;
    end

    always_comb begin
        imm_ext_d = '0;
        case (imm_src_d)
            2'b00:   imm_ext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
            2'b01:   imm_ext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            2'b10:   imm_ext_d = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7],
                                  instr_d[30:25], instr_d[11:8], 1'b0};
            default: imm_ext_d = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12],
                                  instr_d[20], instr_d[30:21], 1'b0};
        endcase
    end

    assign d_s = '{valid: valid_d, reg_write: reg_write_d, alu_src: alu_src_d,
                   mem_write: mem_write_d, result_src: result_src_d, branch: branch_d,
                   alu_control: alu_control_d, rd1: rd1_d, rd2: rd2_d, imm_ext: imm_ext_d,
                   pc: pc_d, pc_plus4: pc_plus4_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d};

    // rs2 is compared even for formats without rs2; this is deliberately conservative.
    assign hazard  = e_q.valid && e_q.result_src && (e_q.rd != '0) && valid_d &&
                     ((rs1_d == e_q.rd) || (rs2_d == e_q.rd));
    assign stall_d = hold_e || (hazard && !flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
        end else if (flush) begin
            e_q <= '0;
        end else if (!hold_e) begin
            e_q <= hazard ? '0 : d_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (hazard && !flush && !hold_e && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign valid_e       = e_q.valid;
    assign reg_write_e   = e_q.reg_write;
    assign alu_src_e     = e_q.alu_src;
    assign mem_write_e   = e_q.mem_write;
    assign result_src_e  = e_q.result_src;
    assign branch_e      = e_q.branch;
    assign alu_control_e = e_q.alu_control;
    assign rd1_e         = e_q.rd1;
    assign rd2_e         = e_q.rd2;
    assign imm_ext_e     = e_q.imm_ext;
    assign pc_e          = e_q.pc;
    assign pc_plus4_e    = e_q.pc_plus4;
    assign rs1_e         = e_q.rs1;
    assign rs2_e         = e_q.rs2;
    assign rd_e          = e_q.rd;

endmodule
